// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_div restoring divider.
package seq_div_pkg;

  localparam int unsigned SEQ_DIV_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width: enough to count 0..w-1, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_div_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned DATAWIDTH = SEQ_DIV_DW
) (
  input  logic [DATAWIDTH-1:0] prem,
  input  logic                 bit_in,
  input  logic [DATAWIDTH-1:0] dvs,
  output logic [DATAWIDTH-1:0] nrem,
  output logic                 qbit
);

  logic [DATAWIDTH:0] shifted;
  logic [DATAWIDTH:0] diff;

  always_comb begin
    shifted = {prem, bit_in};
    diff    = shifted - {1'b0, dvs};
    // A clear top bit means the trial subtraction did not borrow.
    qbit    = ~diff[DATAWIDTH];
    nrem    = qbit ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; default build is unsigned only.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned DATAWIDTH = SEQ_DIV_DW
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 div_by_zero
);

  localparam int unsigned CW = cnt_w(DATAWIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATAWIDTH-1:0] dvd;   // dividend shifts out at the top, quotient bits fill in at the bottom
  logic [DATAWIDTH-1:0] dvs;
  logic [DATAWIDTH-1:0] prem;
  logic [DATAWIDTH-1:0] nrem;
  logic                 qbit;
  logic [DATAWIDTH-1:0] qraw;

  div_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .prem  (prem),
    .bit_in(dvd[DATAWIDTH-1]),
    .dvs   (dvs),
    .nrem  (nrem),
    .qbit  (qbit)
  );

  assign qraw = {dvd[DATAWIDTH-2:0], qbit};
  assign busy = (state == CALC);
  assign done = (state == DONE);

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic [DATAWIDTH-1:0] a_mag;
  logic [DATAWIDTH-1:0] b_mag;

  assign a_mag = a[DATAWIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[DATAWIDTH-1] ? (~b + 1'b1) : b;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if ((state != CALC) && start && (b != '0)) begin
      neg_q <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
      neg_r <= a[DATAWIDTH-1];
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (b == '0) begin
              quot        <= '1;
              rem         <= a;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
`ifdef SEQ_DIV_SIGNED_EN
              dvd <= a_mag;
              dvs <= b_mag;
`else
              dvd <= a;
              dvs <= b;
`endif
              prem  <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          prem <= nrem;
          dvd  <= qraw;
          if (cnt == LAST) begin
`ifdef SEQ_DIV_SIGNED_EN
            // Signs are folded in on the completion edge so no extra cycle is spent.
            quot <= neg_q ? (~qraw + 1'b1) : qraw;
            rem  <= neg_r ? (~nrem + 1'b1) : nrem;
`else
            quot <= qraw;
            rem  <= nrem;
`endif
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed timing cases plus randomized operands vs. an arithmetic model.
module tb_seq_div;

  localparam int unsigned DW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quot;
  logic [DW-1:0] rem;
  logic          div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_div #(.DATAWIDTH(DW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the zero-divide convention.
  task automatic model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       output logic [DW-1:0] q, output logic [DW-1:0] r, output logic z);
    longint sa, sb;
`ifdef SEQ_DIV_SIGNED_EN
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
`else
    sa = longint'(av);
    sb = longint'(bv);
`endif
    if (sb == 0) begin
      q = '1;
      r = av;
      z = 1'b1;
    end else begin
      q = DW'(sa / sb);
      r = DW'(sa % sb);
      z = 1'b0;
    end
  endtask

  // Called on a negedge; returns on the negedge right after the accepting edge.
  task automatic issue(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Latency counts edges from the accepting edge, inclusive, until done is seen.
  task automatic wait_done(input int lat_in, output int lat, output int bcnt);
    lat = lat_in;
    bcnt = 0;
    while (!done && lat < 64) begin
      if (busy) bcnt++;
      @(negedge Clk);
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    logic [DW-1:0] eq, er;
    logic ez;
    int lat, bc;
    model(av, bv, eq, er, ez);
    issue(av, bv);
    wait_done(1, lat, bc);
    check({tag, "_quot"}, 64'(quot), 64'(eq));
    check({tag, "_rem"}, 64'(rem), 64'(er));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    check({tag, "_lat"}, 64'(lat), ez ? 64'd1 : 64'(DW + 1));
`ifndef SEQ_DIV_SIGNED_EN
    if (!ez) begin
      check({tag, "_inv"}, 64'(quot) * 64'(bv) + 64'(rem), 64'(av));
      check({tag, "_remlt"}, 64'(rem < bv), 64'd1);
    end
`endif
  endtask

  initial begin
    int lat, bc, seen;
    logic [DW-1:0] ra, rb;

    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quot", 64'(quot), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Basic unsigned: 200/7
    issue(8'd200, 8'd7);
    wait_done(1, lat, bc);
    check("basic_lat", 64'(lat), 64'(DW + 1));
    check("basic_busy_cycles", 64'(bc), 64'(DW));
    check("basic_quot", 64'(quot), 64'd28);
    check("basic_rem", 64'(rem), 64'd4);
    check("basic_dbz", 64'(div_by_zero), 64'd0);
    @(negedge Clk);
    check("basic_done_1cyc", 64'(done), 64'd0);
    check("basic_hold_quot", 64'(quot), 64'd28);

    // Asynchronous reset in the middle of an iteration
    issue(8'd200, 8'd7);
    @(posedge Clk);
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_quot", 64'(quot), 64'd0);
    check("midrst_rem", 64'(rem), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (done || busy) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);

    // Zero divide
    issue(8'd55, 8'd0);
    check("dbz_done", 64'(done), 64'd1);
    check("dbz_quot", 64'(quot), 64'd255);
    check("dbz_rem", 64'(rem), 64'd55);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    seen = busy ? 1 : 0;
    @(negedge Clk);
    if (busy) seen++;
    check("dbz_busy_never", 64'(seen), 64'd0);
    check("dbz_done_1cyc", 64'(done), 64'd0);

    // Back-to-back, with a start pulse during CALC that must be ignored
    issue(8'd255, 8'd1);
    @(negedge Clk);
    start = 1'b1;
    a = 8'd9;
    b = 8'd4;
    @(negedge Clk);
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    wait_done(3, lat, bc);
    check("b2b_first_lat", 64'(lat), 64'(DW + 1));
    check("b2b_first_quot", 64'(quot), 64'd255);
    check("b2b_first_rem", 64'(rem), 64'd0);
    check("b2b_dbz_clear", 64'(div_by_zero), 64'd0);
    issue(8'd9, 8'd4);
    check("b2b_no_gap", 64'(busy), 64'd1);
    check("b2b_hold_quot", 64'(quot), 64'd255);
    check("b2b_hold_rem", 64'(rem), 64'd0);
    wait_done(1, lat, bc);
    check("b2b_second_lat", 64'(lat), 64'(DW + 1));
    check("b2b_second_quot", 64'(quot), 64'd2);
    check("b2b_second_rem", 64'(rem), 64'd1);
    @(negedge Clk);

`ifdef SEQ_DIV_SIGNED_EN
    issue(8'hF9, 8'd2);
    wait_done(1, lat, bc);
    check("sgn_m7d2_quot", 64'(quot), 64'hFD);
    check("sgn_m7d2_rem", 64'(rem), 64'hFF);
    @(negedge Clk);
    issue(8'h80, 8'hFF);
    wait_done(1, lat, bc);
    check("sgn_min_quot", 64'(quot), 64'h80);
    check("sgn_min_rem", 64'(rem), 64'h00);
    @(negedge Clk);
`endif

    // Boundary operands
    run_and_check("edge_0", 8'd0, 8'd255);
    @(negedge Clk);
    run_and_check("edge_255_255", 8'd255, 8'd255);
    @(negedge Clk);
    run_and_check("edge_1_255", 8'd1, 8'd255);
    @(negedge Clk);

    // Randomized operands, some issued back-to-back in the done cycle
    for (int i = 0; i < 3000; i++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(1, 4)) : DW'($urandom_range(1, 255));
      run_and_check("rand", ra, rb);
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
